// File: rtl/serial_xmit_engine_if.sv
// Byte handshake between a producer and serial_xmit_engine.
// Latency: none (wires only).
// Backpressure: producer holds data/data_valid until a cycle with ready high.
// Signals: data[7:0] byte, data_valid producer strobe, ready consumer accept.
interface serial_xmit_engine_if;
  logic [7:0] data;
  logic       data_valid;
  logic       ready;

  modport master (output data, output data_valid, input ready);
  modport slave  (input data, input data_valid, output ready);
endinterface

// File: rtl/serial_xmit_engine.sv
// UART-style transmitter: 10-bit frames (start 0, 8 data LSB first, stop 1) on tx.
// Latency: tx falls at the accepting edge (no FIFO) or one edge later (FIFO build).
// Backpressure: ready = IDLE without FIFO; ready = !full with the FIFO.
// Ports: Clk, Rst (sync, active-high), limit[15:0] cycles per bit (0 acts as 1),
//        xfer (data/data_valid/ready handshake), tx (registered, idle high), busy.
// Build option: define SERIAL_XMIT_FIFO_EN for a 4-entry input FIFO with
//               back-to-back frame chaining.
module serial_xmit_engine (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [15:0]            limit,
  serial_xmit_engine_if.slave    xfer,
  output logic                   tx,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [15:0] lim, lim_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [7:0]  shreg, shreg_nxt;
  logic        tx_nxt;
  logic        load;          // take a byte from the source and begin a frame
  logic        src_vld;
  logic [7:0]  src_dat;
  logic        cnt_hit;
  logic [15:0] lim_new;

  assign cnt_hit = (cnt == lim);
  assign lim_new = (limit == 16'd0) ? 16'd1 : limit;

`ifdef SERIAL_XMIT_FIFO_EN
  localparam bit CHAIN_EN = 1'b1;

  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] fifo_cnt;
  logic       push;

  assign xfer.ready = (fifo_cnt != 3'd4);
  assign push       = xfer.data_valid && xfer.ready;
  assign src_vld    = (fifo_cnt != 3'd0);
  assign src_dat    = fifo_mem[rd_ptr];
  assign busy       = (state != IDLE) || src_vld;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      fifo_cnt <= 3'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= xfer.data;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (load) rd_ptr <= rd_ptr + 2'd1;
      // simultaneous push and pop leaves occupancy unchanged
      case ({push, load})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end
`else
  localparam bit CHAIN_EN = 1'b0;

  // Without the FIFO the handshake feeds the shifter directly; a transfer
  // is exactly a load in IDLE.
  assign xfer.ready = (state == IDLE);
  assign src_vld    = xfer.data_valid;
  assign src_dat    = xfer.data;
  assign busy       = (state != IDLE);
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    lim_nxt   = lim;
    shreg_nxt = shreg;
    tx_nxt    = tx;
    load      = 1'b0;

    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (src_vld) load = 1'b1;
      end
      START: begin
        if (cnt_hit) begin
          cnt_nxt   = 16'd1;
          state_nxt = DATA;
          idx_nxt   = 3'd0;
          tx_nxt    = shreg[0];
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      DATA: begin
        if (cnt_hit) begin
          cnt_nxt = 16'd1;
          if (idx == 3'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            idx_nxt = idx + 3'd1;
            tx_nxt  = shreg[idx + 3'd1];
          end
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      STOP: begin
        if (cnt_hit) begin
          cnt_nxt = 16'd1;
          // chaining straight into START gives gap-free frames from the FIFO
          if (CHAIN_EN && src_vld) load = 1'b1;
          else                     state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // limit is captured only here, so mid-frame changes wait for the next frame
    if (load) begin
      state_nxt = START;
      shreg_nxt = src_dat;
      lim_nxt   = lim_new;
      cnt_nxt   = 16'd1;
      idx_nxt   = 3'd0;
      tx_nxt    = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      cnt   <= 16'd1;
      idx   <= 3'd0;
      lim   <= 16'd1;
      shreg <= 8'd0;
      tx    <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      lim   <= lim_nxt;
      shreg <= shreg_nxt;
      tx    <= tx_nxt;
    end
  end

endmodule

// File: tb/tb_serial_xmit_engine.sv
module tb_serial_xmit_engine;

  logic        Clk;
  logic        Rst;
  logic [15:0] limit;
  logic        tx;
  logic        busy;
  int          checks;
  int          errors;

  serial_xmit_engine_if xfer_if ();

  serial_xmit_engine dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .limit (limit),
    .xfer  (xfer_if),
    .tx    (tx),
    .busy  (busy)
  );

`ifdef SERIAL_XMIT_FIFO_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic test_reset();
    Rst = 1'b1;
    limit = 16'd4;
    xfer_if.data = 8'h00;
    xfer_if.data_valid = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (xfer_if.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", xfer_if.ready); end
  endtask

  // Send one byte and check tx/busy/ready every cycle of the frame.
  // exp holds the frame LSB first (bit 0 = start). chg_at >= 0 rewrites limit mid-frame.
  task automatic send_frame(input logic [7:0] b, input logic [15:0] lim_in, input int lim_eff,
                            input logic [9:0] exp, input string nm,
                            input int chg_at, input logic [15:0] chg_val);
    int   waited;
    int   p;
    logic e_tx;
    logic e_busy;
    logic e_rdy;
    @(negedge Clk);
    limit = lim_in;
    xfer_if.data = b;
    xfer_if.data_valid = 1'b1;
    waited = 0;
    while (xfer_if.ready !== 1'b1 && waited < 1000) begin
      @(negedge Clk);
      waited++;
    end
    checks++;
    if (waited >= 1000) begin
      errors++;
      $display("FAIL %s_ready_wait: ready=%b want 1", nm, xfer_if.ready);
    end
    @(posedge Clk);
    #1 xfer_if.data_valid = 1'b0;
    for (int k = 0; k <= 10 * lim_eff + LAT; k++) begin
      @(negedge Clk);
      if (k == chg_at) limit = chg_val;
      p = k - LAT;
      e_tx   = (p >= 0 && p < 10 * lim_eff) ? exp[p / lim_eff] : 1'b1;
      e_busy = (k < 10 * lim_eff + LAT);
      e_rdy  = (LAT == 1) ? 1'b1 : (k >= 10 * lim_eff);
      checks++;
      if (tx !== e_tx) begin
        errors++;
        $display("FAIL %s_tx cycle %0d: got %b want %b", nm, k, tx, e_tx);
      end
      checks++;
      if (busy !== e_busy) begin
        errors++;
        $display("FAIL %s_busy cycle %0d: got %b want %b", nm, k, busy, e_busy);
      end
      checks++;
      if (xfer_if.ready !== e_rdy) begin
        errors++;
        $display("FAIL %s_ready cycle %0d: got %b want %b", nm, k, xfer_if.ready, e_rdy);
      end
    end
  endtask

  task automatic test_basic_frame();
    send_frame(8'hA5, 16'd4, 4, {1'b1, 8'hA5, 1'b0}, "a5_lim4", -1, 16'd0);
  endtask

  task automatic test_min_limit();
    send_frame(8'h01, 16'd0, 1, {1'b1, 8'h01, 1'b0}, "lim0", -1, 16'd0);
    send_frame(8'h01, 16'd1, 1, {1'b1, 8'h01, 1'b0}, "lim1", -1, 16'd0);
  endtask

  task automatic test_limit_change();
    send_frame(8'h55, 16'd8, 8, {1'b1, 8'h55, 1'b0}, "limchg_old", 10, 16'd2);
    send_frame(8'hC3, 16'd2, 2, {1'b1, 8'hC3, 1'b0}, "limchg_new", -1, 16'd0);
  endtask

  task automatic send_hold(input logic [7:0] b);
    int waited;
    @(negedge Clk);
    xfer_if.data = b;
    xfer_if.data_valid = 1'b1;
    waited = 0;
    while (xfer_if.ready !== 1'b1 && waited < 20000) begin
      @(negedge Clk);
      waited++;
    end
    @(posedge Clk);
    #1 xfer_if.data_valid = 1'b0;
  endtask

  // Mid-bit sampling receiver, same timing rule as the receive engine.
  task automatic rx_byte(input int lim, output logic [7:0] b, output bit ok);
    int w;
    ok = 1'b1;
    b = 8'h00;
    w = 0;
    @(negedge Clk);
    while (tx !== 1'b0 && w < 20000) begin
      @(negedge Clk);
      w++;
    end
    if (w >= 20000) begin
      ok = 1'b0;
    end else begin
      repeat (lim / 2) @(negedge Clk);
      if (tx !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (lim) @(negedge Clk);
        b[i] = tx;
      end
      repeat (lim) @(negedge Clk);
      if (tx !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic test_loopback();
    logic [7:0] r0;
    logic [7:0] r1;
    bit         ok0;
    bit         ok1;
    limit = 16'h01B2;
    fork
      begin
        send_hold(8'h3C);
        send_hold(8'hFF);
      end
      begin
        rx_byte(16'h01B2, r0, ok0);
        rx_byte(16'h01B2, r1, ok1);
      end
    join
    checks++;
    if (!ok0 || r0 !== 8'h3C) begin
      errors++;
      $display("FAIL loopback_byte0: got %h framing_ok=%0d want 3c", r0, ok0);
    end
    checks++;
    if (!ok1 || r1 !== 8'hFF) begin
      errors++;
      $display("FAIL loopback_byte1: got %h framing_ok=%0d want ff", r1, ok1);
    end
    repeat (500) @(negedge Clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL loopback_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_mid_reset();
    @(negedge Clk);
    limit = 16'd4;
    xfer_if.data = 8'hF0;
    xfer_if.data_valid = 1'b1;
    @(posedge Clk);
    #1 xfer_if.data_valid = 1'b0;
    for (int k = 0; k < 17; k++) @(negedge Clk);
    // inside data bit 3 of 0xF0, which is a 0
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL midrst_pre_tx: got %b want 0", tx); end
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL midrst_tx: got %b want 1", tx); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++;
    if (xfer_if.ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", xfer_if.ready); end
    send_frame(8'h81, 16'd4, 4, {1'b1, 8'h81, 1'b0}, "after_rst", -1, 16'd0);
  endtask

`ifdef SERIAL_XMIT_FIFO_EN
  task automatic test_back_to_back();
    logic [7:0] bytes [6];
    int         acc_edge [6];
    int         exp_edge [6];
    int         j;
    int         p;
    logic       rdy_s;
    logic       acc;
    logic [9:0] fr;
    logic       e_tx;
    bytes    = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    exp_edge = '{0, 1, 2, 3, 4, 22};
    acc_edge = '{-1, -1, -1, -1, -1, -1};
    j = 0;
    @(negedge Clk);
    limit = 16'd2;
    xfer_if.data = bytes[0];
    xfer_if.data_valid = 1'b1;
    rdy_s = xfer_if.ready;
    for (int c = 0; c <= 61; c++) begin
      @(posedge Clk);
      acc = xfer_if.data_valid && rdy_s;
      @(negedge Clk);
      if (acc) begin
        acc_edge[j] = c;
        j++;
        if (j < 6) xfer_if.data = bytes[j];
        else       xfer_if.data_valid = 1'b0;
      end
      rdy_s = xfer_if.ready;
      if (c == 4 || c == 20) begin
        checks++;
        if (rdy_s !== 1'b0) begin errors++; $display("FAIL b2b_ready_full c=%0d: got %b want 0", c, rdy_s); end
      end
      if (c == 21) begin
        checks++;
        if (rdy_s !== 1'b1) begin errors++; $display("FAIL b2b_ready_rise: got %b want 1", rdy_s); end
      end
      p = c - 1;
      if (p >= 0 && p < 60) begin
        fr   = {1'b1, bytes[p / 20], 1'b0};
        e_tx = fr[(p % 20) / 2];
      end else begin
        e_tx = 1'b1;
      end
      checks++;
      if (tx !== e_tx) begin errors++; $display("FAIL b2b_tx c=%0d: got %b want %b", c, tx, e_tx); end
      checks++;
      if (busy !== (c < 61)) begin errors++; $display("FAIL b2b_busy c=%0d: got %b want %b", c, busy, (c < 61)); end
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (acc_edge[i] !== exp_edge[i]) begin
        errors++;
        $display("FAIL b2b_accept_edge %0d: got %0d want %0d", i, acc_edge[i], exp_edge[i]);
      end
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_frame();
    test_min_limit();
    test_limit_change();
    test_loopback();
    test_mid_reset();
`ifdef SERIAL_XMIT_FIFO_EN
    test_back_to_back();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
